// File: rtl/robs_accum_buffer.sv
// Block accumulator for signed multiplier products: sums a programmable number of
// products with saturation and queues each finished block sum in a 2-entry FIFO.
module robs_accum_buffer #(
    parameter int WIDTH       = 8,
    parameter int ACC_WIDTH   = 24,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   prod_valid,
    input  logic [2*WIDTH-1:0]     product,
    output logic                   prod_ready,
    input  logic [COUNT_WIDTH-1:0] block_len,
    input  logic                   clear,
    output logic                   out_valid,
    output logic [ACC_WIDTH-1:0]   out_data,
    output logic                   out_sat,
    input  logic                   out_ready,
    output logic                   acc_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [COUNT_WIDTH:0] MAX_LEN = {1'b1, {COUNT_WIDTH{1'b0}}};
    localparam logic [COUNT_WIDTH:0] ONE     = {{COUNT_WIDTH{1'b0}}, 1'b1};
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                 state, state_next;
    logic [COUNT_WIDTH:0]   count, count_next;
    logic [COUNT_WIDTH:0]   len_q, len_next;
    logic [COUNT_WIDTH:0]   req_len, cur_len, count_inc;
    logic [ACC_WIDTH-1:0]   acc, acc_next, acc_result;
    logic                   sat_sticky, sat_next, sat_now;
    logic [ACC_WIDTH:0]     acc_ext, prod_ext, sum;
    logic                   accept, last, push, pop;

    logic [1:0]             occ;
    logic [ACC_WIDTH-1:0]   head_data, tail_data;
    logic                   head_sat, tail_sat;
    logic [ACC_WIDTH-1:0]   push_data;
    logic                   push_sat;

    // Ready looks only at registered occupancy so a same-cycle pop never opens a slot.
    assign prod_ready = !reset && !clear && (occ != 2'd2);
    assign accept     = prod_valid && prod_ready;

    assign req_len   = (block_len == '0) ? MAX_LEN : {1'b0, block_len};
    assign cur_len   = (state == IDLE) ? req_len : len_q;
    assign count_inc = count + ONE;
    assign last      = accept && (count_inc == cur_len);

    // One guard bit above the accumulator exposes overflow in either direction.
    assign acc_ext  = {acc[ACC_WIDTH-1], acc};
    assign prod_ext = {{(ACC_WIDTH+1-2*WIDTH){product[2*WIDTH-1]}}, product};
    assign sum      = acc_ext + prod_ext;
    assign sat_now  = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];

    always_comb begin
        acc_result = sum[ACC_WIDTH-1:0];
        if (sat_now) begin
            acc_result = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    assign push      = last;
    assign push_data = acc_result;
    assign push_sat  = sat_sticky | sat_now;
    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = head_data;
    assign out_sat   = head_sat;
    assign acc_busy  = (state == ACCUM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            len_q      <= '0;
            acc        <= '0;
            sat_sticky <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            len_q      <= len_next;
            acc        <= acc_next;
            sat_sticky <= sat_next;
        end
    end

    // Clear outranks acceptance; the final product of a block returns everything to IDLE.
    always_comb begin
        state_next = state;
        count_next = count;
        len_next   = len_q;
        acc_next   = acc;
        sat_next   = sat_sticky;
        if (clear) begin
            state_next = IDLE;
            count_next = '0;
            acc_next   = '0;
            sat_next   = 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                len_next = req_len;
            end
            if (last) begin
                state_next = IDLE;
                count_next = '0;
                acc_next   = '0;
                sat_next   = 1'b0;
            end else begin
                state_next = ACCUM;
                count_next = count_inc;
                acc_next   = acc_result;
                sat_next   = sat_sticky | sat_now;
            end
        end
    end

    // Head/tail register pair; the head keeps its value after the final pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ       <= 2'd0;
            head_data <= '0;
            head_sat  <= 1'b0;
            tail_data <= '0;
            tail_sat  <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_data <= push_data;
                        head_sat  <= push_sat;
                        occ       <= 2'd1;
                    end else begin
                        tail_data <= push_data;
                        tail_sat  <= push_sat;
                        occ       <= 2'd2;
                    end
                end
                2'b01: begin
                    if (occ == 2'd2) begin
                        head_data <= tail_data;
                        head_sat  <= tail_sat;
                    end
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    head_data <= push_data;
                    head_sat  <= push_sat;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
